// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares one memory request port between NUM_REQ requesters. A round-robin
//   arbiter loads the winning MemReq into a registered output stage. Granted
//   reads push the requester id into an in-order FIFO. Each returning read
//   response pops the head id and is steered back to that requester.
//
//   A MemReq is 65 bits packed: {is_write[64], address[63:32], wdata[31:0]}.
//
// Ports
//   clk            : clock, all state on rising edge
//   rst_n          : asynchronous active-low reset
//   req_valid      : per-requester request valid
//   req_data       : packed MemReq array, requester i at [i*65 +: 65]
//   req_ready      : one-hot grant (combinational)
//   mem_req_valid  : registered request valid toward memory
//   mem_req        : registered MemReq toward memory
//   mem_req_ready  : memory consumes mem_req this cycle
//   mem_resp_valid : in-order read data return, no backpressure
//   mem_resp_data  : read data
//   resp_valid     : one-hot response strobe (registered, 1-cycle pulse)
//   resp_data      : read data for the strobed requester (registered, held)
//   err_resp       : sticky flag, a response arrived with no read outstanding
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_READS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*65-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   mem_req_valid,
    output logic [64:0]            mem_req,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [31:0]            mem_resp_data,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data,
    output logic                   err_resp
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int FIFO_AW = (MAX_READS > 1) ? $clog2(MAX_READS) : 1;
    localparam int CNT_W   = $clog2(MAX_READS + 1);

    // Registered state
    logic [ID_W-1:0]    ptr_reg;
    logic [CNT_W-1:0]   reads_in_flight_reg;
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic               mem_req_valid_reg;
    logic [64:0]        mem_req_reg;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic [31:0]        resp_data_reg;
    logic               err_resp_reg;

    logic [ID_W-1:0]    fifo_mem [MAX_READS];

    // Combinational helpers
    logic [64:0]        req_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic               fifo_empty;
    logic               pop;
    logic               read_room;
    logic               slot_free;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      cand;
    logic [64:0]        granted_req;
    logic               push;
    logic [ID_W-1:0]    head_id;

    // The FIFO occupancy is exactly the number of reads in flight.
    assign fifo_empty = (reads_in_flight_reg == '0);
    assign pop        = mem_resp_valid && !fifo_empty;
    // A same-cycle pop frees an entry before the grant is judged.
    assign read_room  = (reads_in_flight_reg < CNT_W'(MAX_READS)) || pop;
    assign slot_free  = !mem_req_valid_reg || mem_req_ready;
    assign head_id    = fifo_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_arr[gi]  = req_data[gi*65 +: 65];
            // Writes are never throttled by the read limit.
            assign eligible[gi] = req_valid[gi] && (req_arr[gi][64] || read_room);
        end
    endgenerate

    // Round-robin scan starting at ptr_reg, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && slot_free && eligible[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign granted_req = req_arr[grant_idx];
    assign push        = grant_found && !granted_req[64];
    assign req_ready   = grant_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx)
                                     : '0;

    // Request stage and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid_reg <= 1'b0;
            mem_req_reg       <= '0;
            ptr_reg           <= '0;
        end else if (slot_free) begin
            if (grant_found) begin
                mem_req_valid_reg <= 1'b1;
                mem_req_reg       <= granted_req;
                ptr_reg           <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0
                                                                     : grant_idx + 1'b1;
            end else begin
                // Consumed with nothing to replace it; payload simply holds.
                mem_req_valid_reg <= 1'b0;
            end
        end
    end

    // ID FIFO storage (no reset needed, validity tracked by the counters)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    // ID FIFO pointers and in-flight count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            reads_in_flight_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == FIFO_AW'(MAX_READS-1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == FIFO_AW'(MAX_READS-1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   reads_in_flight_reg <= reads_in_flight_reg + 1'b1;
                2'b01:   reads_in_flight_reg <= reads_in_flight_reg - 1'b1;
                default: reads_in_flight_reg <= reads_in_flight_reg;
            endcase
        end
    end

    // Response routing and orphan-response detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
            err_resp_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= '0;
            if (pop) begin
                resp_valid_reg <= {{(NUM_REQ-1){1'b0}}, 1'b1} << head_id;
                resp_data_reg  <= mem_resp_data;
            end else if (mem_resp_valid) begin
                err_resp_reg <= 1'b1;
            end
        end
    end

    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req       = mem_req_reg;
    assign resp_valid    = resp_valid_reg;
    assign resp_data     = resp_data_reg;
    assign err_resp      = err_resp_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int MAX_READS = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*65-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mem_req_valid;
    logic [64:0]           mem_req;
    logic                  mem_req_ready = 1'b0;
    logic                  mem_resp_valid = 1'b0;
    logic [31:0]           mem_resp_data = '0;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_data;
    logic                  err_resp;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_arbiter #(.NUM_REQ(NUM_REQ), .MAX_READS(MAX_READS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req(mem_req), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .err_resp(err_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          q[$];          // requester ids of reads granted and not yet answered
    int          m_ptr;
    logic        m_valid;
    logic [64:0] m_req;
    logic [NUM_REQ-1:0] m_rv;
    logic [31:0] m_rd;
    logic        m_err;

    // Whom the spec says wins this cycle, or -1.
    function automatic int exp_grant();
        int pend;
        int i;
        pend = q.size() - ((mem_resp_valid && q.size() > 0) ? 1 : 0);
        if (m_valid && !mem_req_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i] && (req_data[i*65+64] || pend < MAX_READS)) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        int id;
        if (!rst_n) begin
            q.delete();
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_req   <= '0;
            m_rv    <= '0;
            m_rd    <= '0;
            m_err   <= 1'b0;
        end else begin
            g = exp_grant();
            m_rv <= '0;
            if (mem_resp_valid) begin
                if (q.size() > 0) begin
                    id = q.pop_front();
                    m_rv <= NUM_REQ'(1) << id;
                    m_rd <= mem_resp_data;
                end else begin
                    m_err <= 1'b1;
                end
            end
            if (!m_valid || mem_req_ready) begin
                if (g >= 0) begin
                    m_valid <= 1'b1;
                    m_req   <= req_data[g*65 +: 65];
                    m_ptr   <= (g + 1) % NUM_REQ;
                    if (!req_data[g*65+64]) q.push_back(g);
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin : compare
        int g;
        if (rst_n) begin
            g = exp_grant();
            check("req_ready", 65'(req_ready), (g >= 0) ? 65'(NUM_REQ'(1) << g) : 65'd0);
            check("mem_req_valid", 65'(mem_req_valid), 65'(m_valid));
            if (m_valid) check("mem_req", mem_req, m_req);
            check("resp_valid", 65'(resp_valid), 65'(m_rv));
            check("resp_data", 65'(resp_data), 65'(m_rd));
            check("err_resp", 65'(err_resp), 65'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[i] = v;
        req_data[i*65 +: 65] = {w, a, d};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_mem_req_valid", 65'(mem_req_valid), 65'd0);
        check("rst_resp_valid", 65'(resp_valid), 65'd0);
        check("rst_err", 65'(err_resp), 65'd0);
    endtask

    int cnt0, cnt1;
    logic [64:0] held;

    initial begin
        // ---- 1: single read ----
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        mem_req_ready = 1'b1;
        #1 check("t1_grant", 65'(req_ready), 65'd1);
        tick();
        check("t1_mem_req_valid", 65'(mem_req_valid), 65'd1);
        check("t1_mem_req", mem_req, {1'b0, 32'h10, 32'h0});
        req_valid = '0;
        tick();
        check("t1_consumed", 65'(mem_req_valid), 65'd0);
        tick();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        check("t1_resp_valid", 65'(resp_valid), 65'd1);
        check("t1_resp_data", 65'(resp_data), 65'h0DEADBEEF);
        tick();
        check("t1_resp_pulse", 65'(resp_valid), 65'd0);
        check("t1_resp_hold", 65'(resp_data), 65'h0DEADBEEF);

        // ---- 2: fairness with two continuous requesters ----
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h100, 32'hA0);
        set_req(1, 1'b1, 1'b1, 32'h200, 32'hB0);
        mem_req_ready = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t2_alternate", 65'(req_ready), (c % 2 == 0) ? 65'd1 : 65'd2);
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            tick();
        end
        check("t2_share0", 65'(cnt0), 65'd4);
        check("t2_share1", 65'(cnt1), 65'd4);

        // ---- 3: backpressure ----
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h30, 32'h3);
        #1 check("t3_first_grant", 65'(req_ready), 65'd1);
        tick();
        held = mem_req;
        check("t3_loaded", held, {1'b1, 32'h30, 32'h3});
        set_req(0, 1'b1, 1'b1, 32'h31, 32'h4);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t3_no_grant", 65'(req_ready), 65'd0);
            check("t3_stable", mem_req, {1'b1, 32'h30, 32'h3});
            tick();
        end
        mem_req_ready = 1'b1;
        #1 check("t3_resume", 65'(req_ready), 65'd1);
        tick();
        check("t3_next", mem_req, {1'b1, 32'h31, 32'h4});
        req_valid = '0;
        tick();

        // ---- 4: read limit ----
        do_reset();
        mem_req_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1 check("t4_read_grant", 65'(req_ready), 65'd1);
            tick();
        end
        #1 check("t4_stall", 65'(req_ready), 65'd0);
        set_req(1, 1'b1, 1'b1, 32'h50, 32'h5);
        #1 check("t4_write_passes", 65'(req_ready), 65'd2);
        tick();
        req_valid[1] = 1'b0;
        #1 check("t4_still_stalled", 65'(req_ready), 65'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h1111;
        #1 check("t4_unblock", 65'(req_ready), 65'd1);
        tick();
        mem_resp_valid = 1'b0;
        check("t4_resp", 65'(resp_valid), 65'd1);
        check("t4_resp_data", 65'(resp_data), 65'h1111);
        #1 check("t4_full_again", 65'(req_ready), 65'd0);
        req_valid = '0;
        tick();

        // ---- 5: interleaved in-order responses ----
        do_reset();
        mem_req_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h64, 32'h0);
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h68, 32'h0);
        tick();
        req_valid = '0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hAAAA0001;
        tick();
        check("t5_a_valid", 65'(resp_valid), 65'd1);
        check("t5_a_data", 65'(resp_data), 65'hAAAA0001);
        mem_resp_data = 32'hBBBB0002;
        tick();
        check("t5_b_valid", 65'(resp_valid), 65'd2);
        check("t5_b_data", 65'(resp_data), 65'hBBBB0002);
        mem_resp_data = 32'hCCCC0003;
        tick();
        mem_resp_valid = 1'b0;
        check("t5_c_valid", 65'(resp_valid), 65'd1);
        check("t5_c_data", 65'(resp_data), 65'hCCCC0003);
        tick();
        check("t5_idle", 65'(resp_valid), 65'd0);

        // ---- 6: orphan response and async reset ----
        do_reset();
        mem_req_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h70, 32'h0);
        tick();
        req_valid = '0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h55;
        tick();
        check("t6_read_back", 65'(resp_data), 65'h55);
        mem_resp_data = 32'h99;
        tick();
        mem_resp_valid = 1'b0;
        check("t6_err_set", 65'(err_resp), 65'd1);
        check("t6_no_strobe", 65'(resp_valid), 65'd0);
        check("t6_data_kept", 65'(resp_data), 65'h55);
        tick();
        tick();
        tick();
        check("t6_err_sticky", 65'(err_resp), 65'd1);
        set_req(0, 1'b1, 1'b1, 32'h80, 32'h8);
        set_req(1, 1'b1, 1'b1, 32'h90, 32'h9);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 65'(mem_req_valid), 65'd0);
        check("t6_rst_mem_req", mem_req, 65'd0);
        check("t6_rst_resp_valid", 65'(resp_valid), 65'd0);
        check("t6_rst_resp_data", 65'(resp_data), 65'd0);
        check("t6_rst_err", 65'(err_resp), 65'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h77;
        tick();
        mem_resp_valid = 1'b0;
        check("t6_post_reset_err", 65'(err_resp), 65'd1);
        check("t6_post_reset_no_strobe", 65'(resp_valid), 65'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
